prob_mul_chain_param: RTL
=========================

// Module: prob_mul_chain_param
// PURPOSE
//  Parametrised bf16 multiply array for probabilistic-circuit product nodes. Takes LANES operand
//  pairs per beat; multiplies each pair, then optionally cascades the lane products. Modes: per-lane,
//  prefix (running) product, or pairwise product. Fully pipelined with valid/ready flow control.
//  Sits between operand fetch and the sum-node/accumulator stage.
// PARAMETERS
//  LANES  6   number of operand pairs per beat (>=2)
//  DW     16  element width; bf16 only (1s/8e/7m), fixed
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset; one clock, synchronous, active-high
//  in_valid   in   1         beat on in_a/in_b/mode is valid
//  in_ready   out  1         block accepts a beat this cycle
//  in_a       in   LANES*DW  operand A, lane k at [k*DW +: DW]
//  in_b       in   LANES*DW  operand B, same packing
//  mode       in   2         00 per-lane, 01 prefix, 10 pairwise, 11 reserved (= 00)
//  out_valid  out  1         result beat valid
//  out_ready  in   1         downstream accepts the result
//  outputs    out  LANES*DW  results, lane k at [k*DW +: DW]
//  out_stbs   out  LANES     per-lane valid; all bits equal out_valid
// BEHAVIOUR
//  - Reset: out_valid=0, out_stbs=0, outputs=0, all pipeline valids=0; in_ready=1 the cycle after.
//    Reset mid-stream discards every in-flight beat; no output beat appears for them.
//  - Handshake: transfer on valid&&ready at either port. Global advance en = !out_valid || out_ready.
//    in_ready = en, combinational, with no dependency on in_valid. out_valid/outputs hold stable
//    while out_valid && !out_ready.
//  - Pipeline: LANES register stages, so latency is LANES cycles from accept to out_valid with no stall.
//    Throughput is 1 beat/cycle. The mode is captured with each beat and travels with it, so a mode
//    change between beats is legal.
//  - Stage 0: p_k = a_k*b_k for every lane.
//  - Stage s (1..LANES-1) computes lane s from stage s-1 values:
//      00: r_s = p_s
//      01: r_s = r_{s-1}*p_s, with r_0 = p_0
//      10: r_s = p_{s-1}*p_s for s odd; r_s = p_s for s even
//    Lanes not yet processed are delayed unchanged; lanes already processed are carried forward.
//  - Each product is one bf16 multiply with a single rounding. Example: prefix of 3 lanes rounds twice.
//  - bf16 multiply:
//      sign = sa^sb
//      exponent = ea+eb-127, +1 if the 16-bit mantissa product >= 2.0
//      round to nearest even on the 7-bit fraction; a rounding carry renormalises
//  - Specials (priority order):
//      any NaN in -> 0x7FC0
//      inf*0 -> 0x7FC0
//      inf*x -> signed inf
//      subnormal input -> treated as signed zero
//      result exponent <= 0 -> signed zero (no subnormal output)
//      result exponent >= 255 -> signed inf 0x7F80/0xFF80
//  - Simultaneous in accept and out drain while full: both occur, nothing is lost or duplicated.
// STRUCTURE
//  - prob_mul_pkg: localparams BF16_QNAN=16'h7FC0, BF16_PINF=16'h7F80, BF16_BIAS=127; typedef enum
//    logic[1:0] mul_mode_t {MODE_LANE, MODE_PREFIX, MODE_PAIR, MODE_RSVD}; function is_nan/is_inf/is_zero.
//  - Sub-module bf16_mul: purely combinational a,b -> z. Instantiated LANES times in stage 0 and
//    LANES-1 times in the chain; registers live only in the top.
// TESTING
//  1. mode=00, all a=0x4000, b=0x3F00 (2*0.5), one beat -> out_valid exactly 6 cycles later,
//     all lanes 0x3F80.
//  2. mode=01, all a=0x4000, b=0x3F80 -> lanes 0..5 = 0x4000,0x4080,0x4100,0x4180,0x4200,0x4280.
//  3. mode=10, all a=0x4040, b=0x3F80 -> lanes 0..5 = 0x4040,0x4110,0x4040,0x4110,0x4040,0x4110.
//  4. Specials, mode=00 (one check per lane):
//       0x7F80*0x0000 -> 0x7FC0
//       0x7F00*0x7F00 -> 0x7F80
//       0xFF00*0x7F00 -> 0xFF80
//       0x0001*0x3F80 -> 0x0000
//       0x0080*0x3F00 -> 0x0000
//       0x3F81*0x3F81 -> 0x3F82 (RNE)
//  5. Backpressure: stream 10 beats with alternating modes; out_ready low for 4 cycles mid-stream
//     -> in_ready low in those same cycles, 10 results in order, none lost or duplicated, outputs
//     stable while stalled.
//  6. Reset mid-stream: 3 beats in flight, rst pulsed 1 cycle -> out_valid=0 and outputs=0 next
//     cycle, no stale result; a fresh beat after reset appears 6 cycles after acceptance.

Source files
------------

// File: rtl/prob_mul_pkg.sv
// Shared definitions for the bf16 product-node multiply array.
//   BF16_QNAN / BF16_PINF / BF16_BIAS : bf16 encodings and exponent bias
//   mul_mode_t                        : cascade mode carried with every beat
//   is_nan / is_inf / is_zero         : operand classifiers (is_zero also
//                                       covers subnormals, which the
//                                       multiplier flushes to zero)
package prob_mul_pkg;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam int          BF16_BIAS = 127;

  typedef enum logic [1:0] {
    MODE_LANE   = 2'b00,
    MODE_PREFIX = 2'b01,
    MODE_PAIR   = 2'b10,
    MODE_RSVD   = 2'b11
  } mul_mode_t;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
  endfunction

  // Zero exponent field: true zero or a subnormal, both handled as zero.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:7] == 8'h00;
  endfunction

endpackage

// File: rtl/bf16_mul.sv
// Combinational bf16 x bf16 -> bf16 multiply, one round-to-nearest-even step.
//   a_i, b_i : bf16 operands
//   z_o      : bf16 product
// Subnormal inputs are flushed to signed zero, results below the normal
// range flush to signed zero and results above it saturate to signed inf.
module bf16_mul
  import prob_mul_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] z_o
);

  logic              sgn;
  logic [15:0]       prod;
  logic [6:0]        frac;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [7:0]        frac_r;
  logic signed [9:0] exp_r;

  always_comb begin
    sgn  = a_i[15] ^ b_i[15];
    // Hidden-one significands; product lies in [1.0, 4.0) with 14 fraction bits.
    prod = {8'd0, 1'b1, a_i[6:0]} * {8'd0, 1'b1, b_i[6:0]};
    if (prod[15]) begin
      frac   = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
    end else begin
      frac   = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end
    rnd    = guard & (sticky | frac[0]);
    // Carry out of the fraction means 1.111..+ulp = 10.0: bump the exponent,
    // fraction bits are already zero.
    frac_r = {1'b0, frac} + {7'd0, rnd};
    // Range -125..385 fits a signed 10-bit value; compute modulo 1024.
    exp_r  = 10'(a_i[14:7]) + 10'(b_i[14:7]) - 10'(BF16_BIAS)
           + 10'(prod[15]) + 10'(frac_r[7]);

    if (is_nan(a_i) || is_nan(b_i))
      z_o = BF16_QNAN;
    else if ((is_inf(a_i) && is_zero(b_i)) || (is_inf(b_i) && is_zero(a_i)))
      z_o = BF16_QNAN;
    else if (is_inf(a_i) || is_inf(b_i))
      z_o = {sgn, BF16_PINF[14:0]};
    else if (is_zero(a_i) || is_zero(b_i))
      z_o = {sgn, 15'd0};
    else if (exp_r <= 10'sd0)
      z_o = {sgn, 15'd0};
    else if (exp_r >= 10'sd255)
      z_o = {sgn, BF16_PINF[14:0]};
    else
      z_o = {sgn, exp_r[7:0], frac_r[6:0]};
  end

endmodule

// File: rtl/prob_mul_chain_param.sv
// Pipelined bf16 multiply array for probabilistic-circuit product nodes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake (in_a, in_b, mode)
//   in_a, in_b          : LANES packed bf16 operands, lane k at [k*DW +: DW]
//   mode                : 00 per-lane, 01 prefix product, 10 pairwise, 11 as 00
//   out_valid/out_ready : result beat handshake
//   outputs             : LANES packed bf16 results
//   out_stbs            : per-lane strobes, all equal to out_valid
// Stage 0 forms the lane products; stage s (1..LANES-1) resolves lane s from
// the stage s-1 vector, so a beat emerges after LANES register stages. All
// stages advance together whenever the output register is free or draining.
module prob_mul_chain_param
  import prob_mul_pkg::*;
#(
  parameter int LANES = 6,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] outputs,
  output logic [LANES-1:0]    out_stbs
);

  logic [LANES-1:0][DW-1:0] a_v, b_v, p_w;
  logic [LANES-1:0][DW-1:0] data_q  [LANES];
  logic [LANES-1:0][DW-1:0] chain_d [LANES-1];  // next value of stage s at [s-1]
  mul_mode_t                mode_q  [LANES-1];  // last stage needs no mode
  logic [LANES-1:0]         vld_q;
  logic                     en;

  assign a_v = in_a;
  assign b_v = in_b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bf16_mul u_mul (
      .a_i (a_v[k]),
      .b_i (b_v[k]),
      .z_o (p_w[k])
    );
  end

  // Lane s-1 of stage s-1 already holds r_{s-1} (prefix) or p_{s-1} (pairwise,
  // s odd, since even lanes pass through), so one multiplier serves both modes.
  for (genvar s = 1; s < LANES; s++) begin : g_chain
    localparam bit ODD = (s % 2) == 1;
    logic [DW-1:0]            prod;
    logic                     use_prod;
    logic [LANES-1:0][DW-1:0] nxt;

    bf16_mul u_mul (
      .a_i (data_q[s-1][s-1]),
      .b_i (data_q[s-1][s]),
      .z_o (prod)
    );

    always_comb begin
      use_prod = (mode_q[s-1] == MODE_PREFIX) || ((mode_q[s-1] == MODE_PAIR) && ODD);
      nxt      = data_q[s-1];
      if (use_prod) nxt[s] = prod;
    end

    assign chain_d[s-1] = nxt;
  end

  assign en = !vld_q[LANES-1] || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < LANES; s++)     data_q[s] <= '0;
      for (int s = 0; s < LANES - 1; s++) mode_q[s] <= MODE_LANE;
    end else if (en) begin
      vld_q <= {vld_q[LANES-2:0], in_valid};
      if (in_valid) begin
        data_q[0] <= p_w;
        mode_q[0] <= mul_mode_t'(mode);
      end
      // Data only moves with a valid beat, so bubbles leave registers untouched.
      for (int s = 1; s < LANES; s++)
        if (vld_q[s-1]) data_q[s] <= chain_d[s-1];
      for (int s = 1; s < LANES - 1; s++)
        if (vld_q[s-1]) mode_q[s] <= mode_q[s-1];
    end
  end

  assign in_ready  = en;
  assign out_valid = vld_q[LANES-1];
  assign outputs   = data_q[LANES-1];
  assign out_stbs  = {LANES{vld_q[LANES-1]}};

endmodule
